byte_swap_stream_ctrl: RTL and testbench

BYTE_SWAP_STREAM_CTRL -- requirements
Module: byte_swap_stream_ctrl

---
 rtl/byte_swap_stream_ctrl.sv | 120 ++++++++++++
 tb/tb_byte_swap_stream_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/byte_swap_stream_ctrl.sv
// Byte-swapping stream stage with one output register and per-packet mode latching.
// Mode is sampled on the first beat of each packet and held until the packet's last beat.
module byte_swap_stream_ctrl #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [1:0]            mode_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_valid_i,
    input  logic                  s_last_i,
    output logic                  s_ready_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    output logic                  m_last_o,
    input  logic                  m_ready_i,
    output logic [1:0]            active_mode_o,
    output logic                  busy_o,
    output logic [15:0]           pkt_cnt_o
);

    localparam int unsigned NumBytes  = DATA_WIDTH / 8;
    localparam int unsigned NumHalves = DATA_WIDTH / 16;

    typedef enum logic [0:0] {StIdle, StInPkt} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  last_q;
    logic [1:0]            mode_q;
    logic [15:0]           cnt_q;

    logic                  s_fire;
    logic                  m_fire;
    logic                  first_beat;
    logic [1:0]            req_mode;
    logic [1:0]            use_mode;
    logic [DATA_WIDTH-1:0] rev_data;
    logic [DATA_WIDTH-1:0] half_data;
    logic [DATA_WIDTH-1:0] conv_data;

    // Reset term keeps the input side ready even before the output register has cleared.
    assign s_ready_o = rst_i | ~valid_q | m_ready_i;
    assign s_fire    = s_valid_i & s_ready_o;
    assign m_fire    = valid_q & m_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (s_fire && !s_last_i) state_d = StInPkt;
            StInPkt: if (s_fire && s_last_i)  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o     = (state_q == StInPkt);
        first_beat = s_fire && (state_q == StIdle);
    end

    // A first beat uses the freshly sampled mode, later beats use the latched one.
    always_comb begin
        req_mode  = (mode_i == 2'd3) ? 2'd0 : mode_i;
        use_mode  = (state_q == StIdle) ? req_mode : mode_q;
        rev_data  = '0;
        half_data = '0;
        for (int unsigned k = 0; k < NumBytes; k++) begin
            rev_data[8*k +: 8] = s_data_i[8*(NumBytes-1-k) +: 8];
        end
        for (int unsigned h = 0; h < NumHalves; h++) begin
            half_data[16*h +: 8]     = s_data_i[16*h+8 +: 8];
            half_data[16*h+8 +: 8]   = s_data_i[16*h +: 8];
        end
        case (use_mode)
            2'd1:    conv_data = rev_data;
            2'd2:    conv_data = half_data;
            default: conv_data = s_data_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            mode_q  <= 2'd0;
            cnt_q   <= 16'd0;
        end else begin
            if (s_fire) begin
                valid_q <= 1'b1;
                data_q  <= conv_data;
                last_q  <= s_last_i;
            end else if (m_fire) begin
                valid_q <= 1'b0;
            end
            if (first_beat) begin
                mode_q <= req_mode;
            end
            if (m_fire && last_q) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign m_data_o      = data_q;
    assign m_valid_o     = valid_q;
    assign m_last_o      = last_q;
    assign active_mode_o = mode_q;
    assign pkt_cnt_o     = cnt_q;

endmodule

// File: tb/tb_byte_swap_stream_ctrl.sv
// Bench for byte_swap_stream_ctrl: directed scenarios plus random traffic,
// checked against a packet-level queue model of the expected output beats.
module tb_byte_swap_stream_ctrl;

    localparam int DW = 32;
    localparam int NB = DW / 8;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [1:0]    mode_i;
    logic [DW-1:0] s_data_i;
    logic          s_valid_i;
    logic          s_last_i;
    logic          s_ready_o;
    logic [DW-1:0] m_data_o;
    logic          m_valid_o;
    logic          m_last_o;
    logic          m_ready_i;
    logic [1:0]    active_mode_o;
    logic          busy_o;
    logic [15:0]   pkt_cnt_o;

    always #5 clk = ~clk;

    byte_swap_stream_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .mode_i        (mode_i),
        .s_data_i      (s_data_i),
        .s_valid_i     (s_valid_i),
        .s_last_i      (s_last_i),
        .s_ready_o     (s_ready_o),
        .m_data_o      (m_data_o),
        .m_valid_o     (m_valid_o),
        .m_last_o      (m_last_o),
        .m_ready_i     (m_ready_i),
        .active_mode_o (active_mode_o),
        .busy_o        (busy_o),
        .pkt_cnt_o     (pkt_cnt_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: pending output beats as {last, data}, packet flag, mode, packet count.
    logic [DW:0] exp_q[$];
    bit          mdl_in_pkt;
    logic [1:0]  mdl_mode;
    logic [15:0] mdl_cnt;
    int          delivered;
    int          busy_cycles;
    bit          last_push;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_conv(input logic [DW-1:0] d, input logic [1:0] m);
        logic [7:0]    b [NB];
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < NB; k++) b[k] = d[8*k +: 8];
        for (int k = 0; k < NB; k++) begin
            if (m == 2'd1)      r[8*k +: 8] = b[NB-1-k];
            else if (m == 2'd2) r[8*k +: 8] = b[k ^ 1];
            else                r[8*k +: 8] = b[k];
        end
        return r;
    endfunction

    task automatic drive(input logic v, input logic l, input logic [1:0] md,
                         input logic [DW-1:0] d, input logic r);
        s_valid_i = v;
        s_last_i  = l;
        mode_i    = md;
        s_data_i  = d;
        m_ready_i = r;
    endtask

    // One clock: compare at the falling edge, advance the model, return 1 after the rising edge.
    task automatic tick();
        bit         do_pop;
        bit         do_push;
        logic [1:0] m;
        @(negedge clk);
        chk("m_valid", m_valid_o, exp_q.size() != 0);
        chk("s_ready", s_ready_o, (exp_q.size() == 0) || m_ready_i);
        chk("busy", busy_o, mdl_in_pkt);
        chk("active_mode", active_mode_o, mdl_mode);
        chk("pkt_cnt", pkt_cnt_o, mdl_cnt);
        if (exp_q.size() != 0) begin
            chk("m_data", m_data_o, exp_q[0][DW-1:0]);
            chk("m_last", m_last_o, exp_q[0][DW]);
        end
        if (busy_o) busy_cycles++;
        do_pop  = (exp_q.size() != 0) && m_ready_i;
        do_push = s_valid_i && ((exp_q.size() == 0) || m_ready_i);
        if (do_pop) begin
            if (exp_q[0][DW]) mdl_cnt = mdl_cnt + 16'd1;
            void'(exp_q.pop_front());
            delivered++;
        end
        if (do_push) begin
            if (!mdl_in_pkt) mdl_mode = (mode_i == 2'd3) ? 2'd0 : mode_i;
            m          = mdl_mode;
            mdl_in_pkt = !s_last_i;
            exp_q.push_back({s_last_i, ref_conv(s_data_i, m)});
        end
        last_push = do_push;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(negedge clk);
        chk("s_ready_in_reset", s_ready_o, 1'b1);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        exp_q.delete();
        mdl_in_pkt = 1'b0;
        mdl_mode   = 2'd0;
        mdl_cnt    = 16'd0;
    endtask

    initial begin
        logic [DW-1:0] held;
        int            i;
        drive(1'b0, 1'b0, 2'd0, '0, 1'b1);
        do_reset();
        chk("reset_m_valid", m_valid_o, 1'b0);
        chk("reset_m_last", m_last_o, 1'b0);
        chk("reset_m_data", m_data_o, '0);
        chk("reset_busy", busy_o, 1'b0);

        // Single-beat full reverse.
        drive(1'b1, 1'b1, 2'd1, 32'h11223344, 1'b1);
        tick();
        chk("rev_data", m_data_o, 32'h44332211);
        chk("rev_last", m_last_o, 1'b1);
        drive(1'b0, 1'b0, 2'd0, '0, 1'b1);
        tick();
        chk("rev_pkt_cnt", pkt_cnt_o, 16'd1);

        // Three-beat half swap; mode change mid-packet must be ignored.
        busy_cycles = 0;
        drive(1'b1, 1'b0, 2'd2, 32'hAABBCCDD, 1'b1);
        tick();
        chk("half_mode", active_mode_o, 2'd2);
        drive(1'b1, 1'b0, 2'd0, 32'hAABBCCDD, 1'b1);
        tick();
        chk("half_data_b2", m_data_o, 32'hBBAADDCC);
        drive(1'b1, 1'b1, 2'd0, 32'hAABBCCDD, 1'b1);
        tick();
        chk("half_data_b3", m_data_o, 32'hBBAADDCC);
        drive(1'b0, 1'b0, 2'd0, '0, 1'b1);
        tick();
        chk("half_busy_cycles", busy_cycles, 2);
        chk("half_mode_kept", active_mode_o, 2'd2);

        // Eight-beat stream with backpressure in cycles 3..5.
        delivered = 0;
        i         = 0;
        held      = '0;
        for (int c = 0; c < 24 && i < 8; c++) begin
            drive(1'b1, i == 7, 2'd1, 32'h1000_0000 + DW'(i), !(c >= 3 && c <= 5));
            #1;
            if (c >= 3 && c <= 5) chk("bp_s_ready_low", s_ready_o, 1'b0);
            if (c == 3) held = m_data_o;
            if (c == 5) chk("bp_data_held", m_data_o, held);
            tick();
            if (last_push) i++;
        end
        drive(1'b0, 1'b0, 2'd0, '0, 1'b1);
        tick();
        tick();
        chk("bp_beats_delivered", delivered, 8);

        // Reserved mode latches as pass.
        drive(1'b1, 1'b1, 2'd3, 32'h01020304, 1'b1);
        tick();
        chk("mode3_data", m_data_o, 32'h01020304);
        chk("mode3_active", active_mode_o, 2'd0);
        drive(1'b0, 1'b0, 2'd0, '0, 1'b1);
        tick();

        // Reset after beat 2 of a 4-beat packet.
        drive(1'b1, 1'b0, 2'd1, 32'hCAFE0001, 1'b1);
        tick();
        drive(1'b1, 1'b0, 2'd1, 32'hCAFE0002, 1'b0);
        tick();
        drive(1'b0, 1'b0, 2'd1, '0, 1'b0);
        do_reset();
        chk("rst_m_valid", m_valid_o, 1'b0);
        chk("rst_pkt_cnt", pkt_cnt_o, 16'd0);
        drive(1'b1, 1'b0, 2'd2, 32'h12345678, 1'b1);
        tick();
        chk("rst_relatch_mode", active_mode_o, 2'd2);
        chk("rst_relatch_data", m_data_o, 32'h34127856);
        drive(1'b1, 1'b1, 2'd1, 32'h9ABCDEF0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 2'd0, '0, 1'b1);
        tick();

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(3) != 0, $urandom_range(3) == 0, 2'($urandom_range(3)),
                  $urandom, $urandom_range(2) != 0);
            tick();
        end
        drive(1'b0, 1'b0, 2'd0, '0, 1'b1);
        tick();
        tick();

        // Packet counter wrap.
        do_reset();
        for (int c = 0; c < 65536; c++) begin
            drive(1'b1, 1'b1, 2'($urandom_range(3)), $urandom, 1'b1);
            tick();
        end
        chk("wrap_cnt_ffff", pkt_cnt_o, 16'hFFFF);
        drive(1'b0, 1'b0, 2'd0, '0, 1'b1);
        tick();
        chk("wrap_cnt_zero", pkt_cnt_o, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
